// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 keyboard receiver with E0/F0 prefix folding and an
// event FIFO (first-word-fall-through, valid/ready).
// Everything runs on i_clk. The PS/2 pins are synchronised and the PS/2
// clock is edge-detected. Each 11-bit frame is checked for start, odd
// parity and stop, and stalled frames are aborted after TIMEOUT_CYC cycles.
// Optional build macro: PS2_RX_FILTER_EN adds a deglitch filter of
// FILTER_LEN consecutive equal samples on both synchronised lines.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_ps2_clk,
    input  logic                          i_ps2_data,
    output logic [7:0]                    o_code,
    output logic                          o_ext,
    output logic                          o_break,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_err_parity,
    output logic                          o_err_frame,
    output logic                          o_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } event_t;

    // Reject parameter sets the logic below cannot honour.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        TIMEOUT_CYC < 16 || SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_bad_params
        $error("ps2_rx_fifo: illegal parameter set");
    end

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   line_clk;
    logic                   line_data;

    // Shift the raw pins through SYNC_STAGES flops; idle level of the bus is 1.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], i_ps2_data};
        end
    end

`ifdef PS2_RX_FILTER_EN
    localparam int FLT_W = $clog2(FILTER_LEN) + 1;
    localparam logic [FLT_W-1:0] FLT_MAX = FLT_W'(FILTER_LEN - 1);

    logic [1:0]       flt_in;
    logic [1:0]       flt_state;
    logic [1:0]       flt_line;
    logic [FLT_W-1:0] flt_cnt [2];

    assign flt_in = {data_sync[SYNC_STAGES-1], clk_sync[SYNC_STAGES-1]};

    // The filtered line follows the input in the cycle of the FILTER_LEN-th
    // consecutive differing sample, so the added latency is FILTER_LEN-1.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            flt_line[i] = (flt_in[i] != flt_state[i] && flt_cnt[i] == FLT_MAX)
                          ? flt_in[i] : flt_state[i];
        end
    end

    // Count consecutive samples that disagree with the settled level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            flt_state <= '1;
            for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (flt_in[i] == flt_state[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == FLT_MAX) begin
                    flt_state[i] <= flt_in[i];
                    flt_cnt[i]   <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + FLT_W'(1);
                end
            end
        end
    end

    assign line_clk  = flt_line[0];
    assign line_data = flt_line[1];
`else
    assign line_clk  = clk_sync[SYNC_STAGES-1];
    assign line_data = data_sync[SYNC_STAGES-1];
`endif

    // ------------------------------------------------------------------
    // Falling-edge detection
    // ------------------------------------------------------------------
    logic prev_clk;
    logic edge_evt;

    // Remember last cycle's PS/2 clock level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) prev_clk <= 1'b1;
        else          prev_clk <= line_clk;
    end

    assign edge_evt = prev_clk & ~line_clk;

    // ------------------------------------------------------------------
    // Frame receiver FSM
    // ------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_q;
    logic             par_q;
    logic [TMR_W-1:0] timer;
    logic             timeout;
    logic             frame_done;

    assign timeout    = (state_q != S_IDLE) && (timer == TMR_MAX);
    assign frame_done = edge_evt && !timeout && (state_q == S_STOP);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next state: advance on PS/2 falling edges; a stall returns to idle.
    // NOTE: the default assignment first keeps every path driven, so no latch.
    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = S_IDLE;
        end else if (edge_evt) begin
            unique case (state_q)
                S_IDLE:   if (!line_data) state_d = S_DATA;
                S_DATA:   if (bit_cnt == 3'd7) state_d = S_PARITY;
                S_PARITY: state_d = S_STOP;
                S_STOP:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Datapath: bit counter, LSB-first shifter, parity latch, stall timer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bit_cnt <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            timer   <= '0;
        end else begin
            if (state_q == S_IDLE || edge_evt) timer <= '0;
            else if (timer != TMR_MAX)         timer <= timer + TMR_W'(1);

            if (edge_evt && !timeout) begin
                case (state_q)
                    S_IDLE:   bit_cnt <= '0;
                    S_DATA: begin
                        shift_q <= {line_data, shift_q[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    S_PARITY: par_q <= line_data;
                    default:  ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame check stage (one cycle after the stop-bit edge)
    // ------------------------------------------------------------------
    logic       chk_valid;
    logic [7:0] chk_byte;
    logic       chk_par_ok;
    logic       chk_stop;
    logic       to_pulse;

    // Register the completed frame and any timeout for decoding next cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            chk_valid  <= 1'b0;
            chk_byte   <= '0;
            chk_par_ok <= 1'b0;
            chk_stop   <= 1'b0;
            to_pulse   <= 1'b0;
        end else begin
            chk_valid <= frame_done;
            to_pulse  <= timeout;
            if (frame_done) begin
                chk_byte   <= shift_q;
                chk_par_ok <= ^{shift_q, par_q};
                chk_stop   <= line_data;
            end
        end
    end

    logic good;
    logic is_e0;
    logic is_f0;
    logic push;
    logic ext_q;
    logic brk_q;

    assign good         = chk_valid && chk_par_ok && chk_stop;
    assign is_e0        = (chk_byte == 8'hE0);
    assign is_f0        = (chk_byte == 8'hF0);
    assign push         = good && !is_e0 && !is_f0;
    assign o_err_parity = chk_valid && !chk_par_ok;
    assign o_err_frame  = (chk_valid && chk_par_ok && !chk_stop) || to_pulse;

    // Prefix flags: set by E0/F0, consumed by the next key code, dropped on error.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (to_pulse || (chk_valid && !good)) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (good) begin
            if (is_e0)      ext_q <= 1'b1;
            else if (is_f0) brk_q <= 1'b1;
            else begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    event_t           mem [FIFO_DEPTH];
    event_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             pop;
    logic             wr_en;

    assign full       = (count == CNT_FULL);
    assign o_valid    = (count != '0);
    assign pop        = o_valid && i_ready;
    assign wr_en      = push && (!full || pop);
    assign o_overflow = push && full && !pop;

    // Storage array.
    // NOTE: the storage array has no reset; occupancy is tracked by the
    // pointers and count, and outputs are gated by o_valid.
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr] <= '{ext: ext_q, brk: brk_q, code: chk_byte};
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head    = mem[rd_ptr];
    assign o_code  = o_valid ? head.code : 8'h00;
    assign o_ext   = o_valid & head.ext;
    assign o_break = o_valid & head.brk;
    assign o_count = count;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: table-driven frame vectors plus
// hand-written sequences for latency, timeout, overflow, full+pop and reset.
module tb_ps2_rx_fifo;

    localparam int DEPTH = 4;
    localparam int TMO   = 64;
    localparam int HALF  = 8;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ev_t;

    typedef struct {
        logic [7:0] code;
        bit         bad_par;
        bit         bad_stop;
        int         exp_par;
        int         exp_frm;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       valid;
    logic [2:0] count;
    logic       err_par;
    logic       err_frm;
    logic       ovf;

    ps2_rx_fifo #(
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TMO),
        .SYNC_STAGES (2),
        .FILTER_LEN  (4)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .o_code       (code),
        .o_ext        (ext),
        .o_break      (brk),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_count      (count),
        .o_err_parity (err_par),
        .o_err_frame  (err_frm),
        .o_overflow   (ovf)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   n_par = 0;
    int   n_frm = 0;
    int   n_ovf = 0;
    ev_t  exp_q[$];
    logic m_ext = 1'b0;
    logic m_brk = 1'b0;
    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: count error pulses and score every accepted FIFO head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (err_par) n_par++;
            if (err_frm) n_frm++;
            if (ovf)     n_ovf++;
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: got %0h expected none", {ext, brk, code});
                end else begin
                    check("pop_event", {22'd0, ext, brk, code}, {22'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // Reference decode: prefix flags and expected events.
    task automatic model_byte(input logic [7:0] b, input bit good, input bit drop);
        if (!good) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (!drop) exp_q.push_back('{ext: m_ext, brk: m_brk, code: b});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(posedge clk); #1 ps2_data = b;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    // Start, eight data bits LSB first, parity (odd unless corrupted).
    task automatic frame_head(input logic [7:0] b, input bit bad_par);
        logic p;
        p = (~^b) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(p);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit drop);
        model_byte(b, !bad_par && !bad_stop, drop);
        frame_head(b, bad_par);
        ps2_bit(!bad_stop);
        repeat (6) @(posedge clk);
    endtask

    // Stop bit split in two so the caller can act cycle-exactly around the edge.
    // Returns 1 time unit after the posedge on which the PS/2 clock is pulled low.
    task automatic stop_low();
        @(posedge clk); #1 ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
    endtask

    task automatic stop_high();
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (6) @(posedge clk);
    endtask

    task automatic drain(input string name);
        @(posedge clk); #1 ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1 ready = 1'b0;
        check({name, "_queue_empty"}, exp_q.size(), 0);
        @(negedge clk);
        check({name, "_valid_low"}, {31'd0, valid}, 0);
        check({name, "_count_zero"}, {29'd0, count}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int f0;
        int o0;

        tbl[0]  = '{8'hF0, 1'b0, 1'b0, 0, 0};
        tbl[1]  = '{8'h1C, 1'b0, 1'b0, 0, 0};   // break 1C
        tbl[2]  = '{8'hE0, 1'b0, 1'b0, 0, 0};
        tbl[3]  = '{8'hF0, 1'b0, 1'b0, 0, 0};
        tbl[4]  = '{8'h75, 1'b0, 1'b0, 0, 0};   // ext+break 75
        tbl[5]  = '{8'hF0, 1'b0, 1'b0, 0, 0};
        tbl[6]  = '{8'h1C, 1'b1, 1'b0, 1, 0};   // parity error drops F0
        tbl[7]  = '{8'h1C, 1'b0, 1'b0, 0, 0};   // plain 1C
        tbl[8]  = '{8'h5A, 1'b0, 1'b1, 0, 1};   // bad stop
        tbl[9]  = '{8'h5A, 1'b1, 1'b1, 1, 0};   // both faults: parity only
        tbl[10] = '{8'hE0, 1'b0, 1'b0, 0, 0};
        tbl[11] = '{8'hE0, 1'b0, 1'b0, 0, 0};
        tbl[12] = '{8'h74, 1'b0, 1'b0, 0, 0};   // ext 74
        tbl[13] = '{8'h00, 1'b0, 1'b0, 0, 0};
        tbl[14] = '{8'hFF, 1'b0, 1'b0, 0, 0};
        tbl[15] = '{8'h29, 1'b0, 1'b0, 0, 0};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {17'd0, code, ext, brk, valid, count, err_par, err_frm, ovf}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Latency: head appears two cycles after the stop-bit edge event.
        model_byte(8'h1C, 1'b1, 1'b0);
        frame_head(8'h1C, 1'b0);
        stop_low();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("lat_valid_d1", {31'd0, valid}, 0);
        @(posedge clk);
        @(negedge clk);
        check("lat_valid_d2", {31'd0, valid}, 1);
        check("lat_head", {22'd0, ext, brk, code}, {22'd0, 2'b00, 8'h1C});
        check("lat_count", {29'd0, count}, 1);
        @(posedge clk); #1 ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0;
        @(negedge clk);
        check("lat_popped", {31'd0, valid}, 0);
        stop_high();

        // Table of frames with a ready consumer.
        @(posedge clk); #1 ready = 1'b1;
        for (int r = 0; r < 16; r++) begin
            p0 = n_par;
            f0 = n_frm;
            send_frame(tbl[r].code, tbl[r].bad_par, tbl[r].bad_stop, 1'b0);
            check($sformatf("row%0d_parity_pulses", r), n_par - p0, tbl[r].exp_par);
            check($sformatf("row%0d_frame_pulses", r), n_frm - f0, tbl[r].exp_frm);
        end
        drain("table");

        // Timeout mid-frame after an E0 prefix: frame error, flags cleared.
        send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
        f0 = n_frm;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        repeat (TMO + 20) @(posedge clk);
        check("timeout_frame_pulse", n_frm - f0, 1);
        m_ext = 1'b0;
        m_brk = 1'b0;
        send_frame(8'h29, 1'b0, 1'b0, 1'b0);
        drain("timeout");

        // Overflow: five codes into a four-entry FIFO.
        o0 = n_ovf;
        for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b0, 1'b0, k == 5);
        @(negedge clk);
        check("ovf_count_full", {29'd0, count}, DEPTH);
        check("ovf_pulses", n_ovf - o0, 1);
        drain("ovf");

        // Full FIFO with a pop in the push cycle: accepted, no overflow.
        for (int k = 0; k < 4; k++) send_frame(8'h11 + 8'(k), 1'b0, 1'b0, 1'b0);
        o0 = n_ovf;
        model_byte(8'h15, 1'b1, 1'b0);
        frame_head(8'h15, 1'b0);
        stop_low();
        repeat (3) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0;
        @(negedge clk);
        check("fullpop_count", {29'd0, count}, DEPTH);
        check("fullpop_no_ovf", n_ovf - o0, 0);
        stop_high();
        drain("fullpop");

        // Asynchronous reset mid-frame with events queued.
        send_frame(8'h33, 1'b0, 1'b0, 1'b0);
        send_frame(8'h34, 1'b0, 1'b0, 1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check("midreset_outputs", {17'd0, code, ext, brk, valid, count, err_par, err_frm, ovf}, 0);
        exp_q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        drain("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
